// File: rtl/uart_fifo_ctrl.sv
// Pointer/level/flag controller for the UART FIFO storage; w_en is combinational with wr, flags follow the registered level one cycle after the edge.
// A push on full is rejected (overflow) unless a pop happens in the same cycle; a pop on empty is ignored (underflow).
module uart_fifo_ctrl #(
    parameter int addr_width = 5,
    parameter int af_margin  = 4,
    parameter int ae_margin  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [addr_width-1:0] w_addr,
    output logic [addr_width-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [addr_width:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** addr_width;
    localparam logic [addr_width:0] DEPTH_L = (addr_width + 1)'(DEPTH);
    localparam logic [addr_width:0] AF_TH   = (addr_width + 1)'(DEPTH - af_margin);
    localparam logic [addr_width:0] AE_TH   = (addr_width + 1)'(ae_margin);

    logic [addr_width-1:0] wptr_q, wptr_d;
    logic [addr_width-1:0] rptr_q, rptr_d;
    logic [addr_width:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic push_ok;
    logic pop_ok;
    logic ovf_set;
    logic udf_set;

    // Status flags decode only from registered level, never from wr/rd.
    always_comb begin
        full         = (level_q == DEPTH_L);
        empty        = (level_q == '0);
        almost_full  = (level_q >= AF_TH);
        almost_empty = (level_q <= AE_TH);
    end

    always_comb begin
        push_ok = wr & (~full | rd) & ~flush;
        pop_ok  = rd & ~empty & ~flush;
        ovf_set = wr & full & ~rd;
        udf_set = rd & empty;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + addr_width'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + addr_width'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + (addr_width + 1)'(1);
                2'b01:   level_d = level_q - (addr_width + 1)'(1);
                default: level_d = level_q;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            if (ovf_set) begin
                overflow_d = 1'b1;
            end else if (clr_err) begin
                overflow_d = 1'b0;
            end
            if (udf_set) begin
                underflow_d = 1'b1;
            end else if (clr_err) begin
                underflow_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        w_en      = push_ok;
        w_addr    = wptr_q;
        r_addr    = rptr_q;
        level     = level_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: a queue-based FIFO model predicts each cycle's outputs, a monitor checks them.
module tb_uart_fifo_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AF_M  = 4;
    localparam int AE_M  = 4;

    logic          clk;
    logic          rst_n;
    logic          flush, clr_err, wr, rd;
    logic          w_en;
    logic [AW-1:0] w_addr, r_addr;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   level;
    logic [7:0]    wdata;
    logic [7:0]    mem [DEPTH];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          w_en;
        logic [AW-1:0] w_addr;
        logic [AW-1:0] r_addr;
        logic [AW:0]   level;
        logic          full, empty, af, ae, ovf, udf;
        logic          pop;
        logic [7:0]    dat;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the FIFO contents as a queue plus total push/pop counts.
    logic [7:0] m_q[$];
    int         m_wc, m_rc;
    logic       m_ovf, m_udf;

    uart_fifo_ctrl #(.addr_width(AW), .af_margin(AF_M), .ae_margin(AE_M)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wr(wr), .rd(rd),
        .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (w_en) mem[w_addr] <= wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wc  = 0;
        m_rc  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic drive(input logic w, input logic r, input logic f, input logic c);
        exp_t it;
        int   n;
        logic push, pop;
        @(negedge clk);
        wr = w; rd = r; flush = f; clr_err = c;
        wdata = 8'($urandom);
        n    = m_q.size();
        push = !f && w && (n < DEPTH || r);
        pop  = !f && r && (n > 0);
        it.w_en   = push;
        it.w_addr = AW'(m_wc % DEPTH);
        it.r_addr = AW'(m_rc % DEPTH);
        it.level  = (AW+1)'(n);
        it.full   = (n == DEPTH);
        it.empty  = (n == 0);
        it.af     = (n >= DEPTH - AF_M);
        it.ae     = (n <= AE_M);
        it.ovf    = m_ovf;
        it.udf    = m_udf;
        it.pop    = pop;
        it.dat    = pop ? m_q[0] : 8'h00;
        exp_q.push_back(it);
        if (f) begin
            model_reset();
        end else begin
            if (w && n == DEPTH && !r) m_ovf = 1'b1;
            else if (c)                m_ovf = 1'b0;
            if (r && n == 0)           m_udf = 1'b1;
            else if (c)                m_udf = 1'b0;
            if (pop) begin
                void'(m_q.pop_front());
                m_rc++;
            end
            if (push) begin
                m_q.push_back(wdata);
                m_wc++;
            end
        end
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                chk("w_en",         32'(w_en),         32'(it.w_en));
                chk("w_addr",       32'(w_addr),       32'(it.w_addr));
                chk("r_addr",       32'(r_addr),       32'(it.r_addr));
                chk("level",        32'(level),        32'(it.level));
                chk("full",         32'(full),         32'(it.full));
                chk("empty",        32'(empty),        32'(it.empty));
                chk("almost_full",  32'(almost_full),  32'(it.af));
                chk("almost_empty", 32'(almost_empty), 32'(it.ae));
                chk("overflow",     32'(overflow),     32'(it.ovf));
                chk("underflow",    32'(underflow),    32'(it.udf));
                if (it.pop) chk("head_data", 32'(mem[r_addr]), 32'(it.dat));
            end
        end
    end

    initial begin : stim
        int waited;
        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wr = 1'b0; rd = 1'b0; wdata = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle after reset
        repeat (2) drive(0, 0, 0, 0);
        // Fill to full, then one extra cycle to observe full
        repeat (DEPTH) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        // Rejected push on full, then clear the error
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        // Simultaneous push/pop while full
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        // Drain to empty, then push/pop on empty
        repeat (DEPTH) drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        // Level 10 then flush with wr asserted
        repeat (9) drive(1, 0, 0, 0);
        drive(1, 0, 1, 0);
        drive(0, 0, 0, 0);
        // clr_err coincident with a new underflow keeps the flag
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 0);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 2000; i++) begin
            logic w, r, f, c;
            int   bias;
            bias = ((i / 150) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(99) < bias);
            r = ($urandom_range(99) < 100 - bias);
            f = ($urandom_range(127) == 0);
            c = ($urandom_range(15) == 0);
            drive(w, r, f, c);
        end

        // Asynchronous reset in the middle of a push burst
        repeat (6) drive(1, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #1;
        chk("rst_level",     32'(level),        32'd0);
        chk("rst_empty",     32'(empty),        32'd1);
        chk("rst_full",      32'(full),         32'd0);
        chk("rst_w_addr",    32'(w_addr),       32'd0);
        chk("rst_r_addr",    32'(r_addr),       32'd0);
        chk("rst_ae",        32'(almost_empty), 32'd1);
        chk("rst_af",        32'(almost_full),  32'd0);
        chk("rst_overflow",  32'(overflow),     32'd0);
        chk("rst_underflow", 32'(underflow),    32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        repeat (3) drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        #3;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
